// File: rtl/refresh_pkg.sv
// refresh_pkg: shared state encoding and width helper for the advanced-refresh controller.
package refresh_pkg;

   typedef enum logic [2:0] {IDLE, DEFER, READ, WRITE, DONE} ref_state_t;

   // Address/counter width for n distinct values, never narrower than one bit.
   function automatic int row_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/refresh_sequencer.sv
// refresh_sequencer: arbitrates refresh requests against host traffic, then
// sweeps every row with a read/write-back pair and pulses cycle_done.
module refresh_sequencer
   import refresh_pkg::*;
#(
   parameter int ROWS      = 32,
   parameter int MAX_DEFER = 8,
   parameter int ROW_W     = row_width(ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             refresh_due,
   input  logic             host_req,
   output logic             host_gnt,
   output logic             ref_rd_en,
   output logic             ref_wr_en,
   output logic [ROW_W-1:0] ref_row,
   output logic             ref_active,
   output logic             urgent,
   output logic             cycle_done
);

   localparam int               DW    = row_width(MAX_DEFER + 1);
   localparam logic [DW-1:0]    DLAST = DW'((MAX_DEFER > 0) ? MAX_DEFER - 1 : 0);
   localparam logic [ROW_W-1:0] RLAST = ROW_W'(ROWS - 1);

   ref_state_t       state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [DW-1:0]    defer_cnt_q, defer_cnt_d;
   logic             holdoff_q, holdoff_d;
   logic             urgent_q, urgent_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         row_q       <= '0;
         defer_cnt_q <= '0;
         holdoff_q   <= 1'b0;
         urgent_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         defer_cnt_q <= defer_cnt_d;
         holdoff_q   <= holdoff_d;
         urgent_q    <= urgent_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      defer_cnt_d = '0;
      holdoff_d   = 1'b0;
      urgent_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // holdoff masks the counter's stale request for the cycle after DONE
            if (!holdoff_q && refresh_due) begin
               urgent_d = host_req && (MAX_DEFER == 0);
               state_d  = (host_req && (MAX_DEFER != 0)) ? DEFER : READ;
            end
         end
         DEFER: begin
            if (!host_req || defer_cnt_q == DLAST) begin
               state_d  = READ;
               urgent_d = host_req;
            end else begin
               defer_cnt_d = defer_cnt_q + DW'(1);
            end
         end
         READ: state_d = WRITE;
         WRITE: begin
            state_d = (row_q == RLAST) ? DONE : READ;
            row_d   = (row_q == RLAST) ? '0 : row_q + ROW_W'(1);
         end
         DONE: begin
            state_d   = IDLE;
            holdoff_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      host_gnt   = host_req && (state_q inside {IDLE, DEFER, DONE});
      ref_rd_en  = state_q == READ;
      ref_wr_en  = state_q == WRITE;
      ref_row    = row_q;
      ref_active = state_q inside {READ, WRITE};
      urgent     = urgent_q;
      cycle_done = state_q == DONE;
   end

endmodule

// File: tb/tb_refresh_sequencer.sv
// tb_refresh_sequencer: directed and randomized checks of two sequencer instances
// (MAX_DEFER=3 and MAX_DEFER=0, ROWS=4) against a burst-position reference model.
module tb_refresh_sequencer;

   logic clk = 1'b0, rst = 1'b0, refresh_due = 1'b0, host_req = 1'b0;
   logic g0, rd0, wr0, a0, u0, d0, g1, rd1, wr1, a1, u1, d1;
   logic [1:0] r0, r1;

   refresh_sequencer #(.ROWS(4), .MAX_DEFER(3)) dut0 (
      .clk(clk), .rst(rst), .refresh_due(refresh_due), .host_req(host_req),
      .host_gnt(g0), .ref_rd_en(rd0), .ref_wr_en(wr0), .ref_row(r0),
      .ref_active(a0), .urgent(u0), .cycle_done(d0));

   refresh_sequencer #(.ROWS(4), .MAX_DEFER(0)) dut1 (
      .clk(clk), .rst(rst), .refresh_due(refresh_due), .host_req(host_req),
      .host_gnt(g1), .ref_rd_en(rd1), .ref_wr_en(wr1), .ref_row(r1),
      .ref_active(a1), .urgent(u1), .cycle_done(d1));

   always #5 clk = ~clk;

   // Output vector: {gnt, rd, wr, row[1:0], active, urgent, done}
   wire [7:0] o0 = {g0, rd0, wr0, r0, a0, u0, d0};
   wire [7:0] o1 = {g1, rd1, wr1, r1, a1, u1, d1};

   int n_pass = 0, n_total = 0;
   bit cmp_en = 1'b0;
   logic [7:0] tr0 [0:15];
   logic [7:0] tr1 [0:15];

   // pos: cycle index within a burst (0..7 read/write, 8 = done), -1 outside.
   // dw: number of deferral cycles already spent, -1 when not deferring.
   typedef struct {int pos; int dw; bit hold; bit urg;} mdl_t;
   mdl_t m0, m1;

   function automatic mdl_t mreset();
      mdl_t m;
      m.pos = -1; m.dw = -1; m.hold = 1'b0; m.urg = 1'b0;
      return m;
   endfunction

   function automatic mdl_t step(mdl_t m, bit due, bit hr, int md);
      mdl_t n = m;
      n.urg = 1'b0;
      if (m.pos >= 0 && m.pos < 8) n.pos = m.pos + 1;
      else if (m.pos == 8) begin n.pos = -1; n.hold = 1'b1; end
      else if (m.dw >= 0) begin
         if (!hr || m.dw == md - 1) begin n.pos = 0; n.urg = hr; n.dw = -1; end
         else n.dw = m.dw + 1;
      end else begin
         n.hold = 1'b0;
         if (!m.hold && due) begin
            if (!hr || md == 0) begin n.pos = 0; n.urg = hr; end
            else n.dw = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [7:0] model_out(mdl_t m, bit hr);
      bit act = m.pos >= 0 && m.pos < 8;
      logic [1:0] row = act ? 2'(m.pos / 2) : 2'd0;
      return {hr & !act, act & (m.pos % 2 == 0), act & (m.pos % 2 == 1), row, act, m.urg, m.pos == 8};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0 <= mreset();
         m1 <= mreset();
      end else begin
         m0 <= step(m0, refresh_due, host_req, 3);
         m1 <= step(m1, refresh_due, host_req, 0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_md3", o0, model_out(m0, host_req));
         chk("model_md0", o1, model_out(m1, host_req));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rec(input int c);
      tr0[c] = o0;
      tr1[c] = o1;
   endtask

   task automatic settle();
      refresh_due = 1'b0;
      host_req = 1'b0;
      repeat (14) tick();
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_out_md3", o0, 8'h00);
      chk("reset_out_md0", o1, 8'h00);
      rst = 1'b1;
      cmp_en = 1'b1;
      tick();
      // Idle burst: rd/wr pairs rows 0..3, done in cycle 9, holdoff ignores due
      refresh_due = 1'b1;
      for (int c = 1; c <= 12; c++) begin tick(); rec(c); end
      for (int k = 0; k < 4; k++) begin
         chk("s1_read", tr0[2*k+1], 32'h44 | (k << 3));
         chk("s1_write", tr0[2*k+2], 32'h24 | (k << 3));
      end
      chk("s1_done", tr0[9], 8'h01);
      chk("s1_holdoff", tr0[10], 8'h00);
      chk("s1_holdoff_idle", tr0[11], 8'h00);
      chk("s1_restart", tr0[12], 8'h44);
      settle();
      // Host held: 4 grant cycles, urgent read, 8 blocked cycles, grant in DONE
      host_req = 1'b1;
      refresh_due = 1'b1;
      #1 rec(0);
      tick(); rec(1);
      refresh_due = 1'b0;
      for (int c = 2; c <= 12; c++) begin tick(); rec(c); end
      for (int c = 0; c < 4; c++) chk("s2_gnt_defer", tr0[c], 8'h80);
      chk("s2_urgent_read", tr0[4], 8'h46);
      chk("s2_after_urgent", tr0[5], 8'h24);
      for (int c = 4; c < 12; c++) chk("s2_gnt_blocked", {31'd0, tr0[c][7]}, 0);
      chk("s2_done_gnt", tr0[12], 8'h81);
      chk("s6_md0_urgent", tr1[1], 8'h46);
      chk("s6_md0_write", tr1[2], 8'h24);
      settle();
      // Host leaves after one deferral cycle
      host_req = 1'b1;
      refresh_due = 1'b1;
      tick();
      host_req = 1'b0;
      refresh_due = 1'b0;
      for (int c = 2; c <= 10; c++) begin tick(); rec(c); end
      chk("s3_read_not_urgent", tr0[2], 8'h44);
      chk("s3_last_write", tr0[9], 8'h3C);
      chk("s3_done", tr0[10], 8'h01);
      settle();
      // Host request during WRITE of row 1 is ignored
      refresh_due = 1'b1;
      tick();
      refresh_due = 1'b0;
      repeat (3) tick();
      host_req = 1'b1;
      #1 chk("s4_no_gnt_in_write", o0, 8'h2C);
      tick(); rec(5);
      host_req = 1'b0;
      for (int c = 6; c <= 9; c++) begin tick(); rec(c); end
      chk("s4_read_row2", tr0[5], 8'h54);
      chk("s4_done", tr0[9], 8'h01);
      settle();
      // Asynchronous reset during READ of row 2, then restart at row 0
      refresh_due = 1'b1;
      repeat (5) tick();
      chk("s5_read_row2", o0, 8'h54);
      #2 rst = 1'b0;
      #1 chk("s5_async_md3", o0, 8'h00);
      chk("s5_async_md0", o1, 8'h00);
      tick();
      rst = 1'b1;
      tick();
      chk("s5_restart_row0", o0, 8'h44);
      settle();
      // Randomized traffic with occasional mid-cycle resets
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (!rst) rst = 1'b1;
         refresh_due = $urandom_range(0, 3) == 0;
         if ($urandom_range(0, 3) == 0) host_req = ~host_req;
         if ($urandom_range(0, 299) == 0) begin #2 rst = 1'b0; end
      end
      tick();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
